// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and per-state output encoding for the reset/clock-enable sequencer
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        OVERLAP,
        RUN,
        DONE
    } seq_state_e;

    localparam int CNT_W_DEFAULT = 8;

    typedef struct packed {
        logic rst;
        logic ce;
        logic busy;
        logic done;
    } seq_out_t;

    localparam seq_out_t OUT_IDLE    = seq_out_t'(4'b1000);
    localparam seq_out_t OUT_HOLD    = seq_out_t'(4'b1010);
    localparam seq_out_t OUT_OVERLAP = seq_out_t'(4'b1110);
    localparam seq_out_t OUT_RUN     = seq_out_t'(4'b0110);
    localparam seq_out_t OUT_DONE    = seq_out_t'(4'b0001);

    function automatic seq_out_t state_outputs(input seq_state_e s);
        case (s)
            HOLD:    return OUT_HOLD;
            OVERLAP: return OUT_OVERLAP;
            RUN:     return OUT_RUN;
            DONE:    return OUT_DONE;
            default: return OUT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// rtl/cycle_down_counter.sv - loadable down counter that saturates at zero
module cycle_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec_en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // load wins over decrement; decrement is suppressed at zero so it never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec_en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rst_ce_sequencer.sv
// rtl/rst_ce_sequencer.sv - drives a downstream reset/clock-enable pair: hold, overlap, run, done
module rst_ce_sequencer
    import seq_pkg::*;
#(
    parameter int HOLD_CYCLES    = 3,
    parameter int OVERLAP_CYCLES = 1,
    parameter int RUN_CYCLES     = 6,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    output logic dut_rst_o,
    output logic dut_ce_o,
    output logic busy_o,
    output logic done_o
);

    localparam longint CNT_MAX = (64'(1) << CNT_W) - 1;

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 1");
    end
    if (OVERLAP_CYCLES < 1) begin : g_bad_overlap
        $error("OVERLAP_CYCLES must be at least 1");
    end
    if (RUN_CYCLES < 0) begin : g_bad_run
        $error("RUN_CYCLES must not be negative");
    end
    if ((longint'(HOLD_CYCLES) > CNT_MAX) || (longint'(OVERLAP_CYCLES) > CNT_MAX) ||
        (longint'(RUN_CYCLES) > CNT_MAX)) begin : g_bad_width
        $error("a cycle count does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] OVERLAP_LOAD = CNT_W'(OVERLAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LOAD     = (RUN_CYCLES == 0) ? '0 : CNT_W'(RUN_CYCLES - 1);
    localparam logic             RUN_BOUNDED  = (RUN_CYCLES != 0);

    seq_state_e       state;
    seq_state_e       next_state;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    cycle_down_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec_en   (cnt_dec),
        .zero     (cnt_zero)
    );

    // next state and counter control share one decision so they cannot disagree
    always_comb begin
        next_state   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    next_state   = HOLD;
                    cnt_load     = 1'b1;
                    cnt_load_val = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (cnt_zero) begin
                    next_state   = OVERLAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = OVERLAP_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            OVERLAP: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (cnt_zero) begin
                    next_state   = RUN;
                    cnt_load     = 1'b1;
                    cnt_load_val = RUN_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RUN: begin
                if (stop || (RUN_BOUNDED && cnt_zero)) begin
                    next_state = DONE;
                end else begin
                    cnt_dec = RUN_BOUNDED;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            {dut_rst_o, dut_ce_o, busy_o, done_o} <= OUT_IDLE;
        end else begin
            state <= next_state;
            {dut_rst_o, dut_ce_o, busy_o, done_o} <= state_outputs(next_state);
        end
    end

endmodule
